// File: rtl/regfile_sb.sv
// Scoreboarded integer register file: x0 reads as zero, per-register busy bits.
// Define REGFILE_BYPASS_EN to forward an in-flight writeback to the read ports.
module regfile_sb #(
   parameter  int XLEN    = 32,
   parameter  int NREGS   = 32,
   parameter  int NRPORTS = 2,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NRPORTS*AW-1:0]   rs_addr,
   output logic [NRPORTS*XLEN-1:0] rs_data,
   output logic [NRPORTS-1:0]      rs_busy,
   input  logic                    w_en,
   input  logic [AW-1:0]           w_addr,
   input  logic [XLEN-1:0]         w_data,
   input  logic                    rsv_en,
   input  logic [AW-1:0]           rsv_addr,
   output logic [NREGS-1:0]        busy_vec
);

   // Only registers 1..NREGS-1 are stored; address decode by equality means
   // index 0 and out-of-range addresses never match anything.
   logic [XLEN-1:0]  mem_q [1:NREGS-1];
   logic [XLEN-1:0]  mem_d [1:NREGS-1];
   logic [NREGS-1:0] busy_q, busy_d;

   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      for (int unsigned i = 1; i < NREGS; i++) begin
         if (w_en && (w_addr == AW'(i))) begin
            mem_d[i]  = w_data;
            busy_d[i] = 1'b0;
         end
         // Reservation applied last so a newer producer keeps the register busy.
         if (rsv_en && (rsv_addr == AW'(i))) begin
            busy_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 1; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

`ifdef REGFILE_BYPASS_EN
   function automatic logic addr_valid(input logic [AW-1:0] a);
      addr_valid = 1'b0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         if (a == AW'(i)) addr_valid = 1'b1;
      end
   endfunction
`endif

   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      for (int unsigned p = 0; p < NRPORTS; p++) begin
         for (int unsigned i = 1; i < NREGS; i++) begin
            if (rs_addr[p*AW +: AW] == AW'(i)) begin
               rs_data[p*XLEN +: XLEN] = mem_q[i];
               rs_busy[p]              = busy_q[i];
            end
         end
`ifdef REGFILE_BYPASS_EN
         if (rst_n && w_en && addr_valid(w_addr) && (w_addr == rs_addr[p*AW +: AW])) begin
            rs_data[p*XLEN +: XLEN] = w_data;
            rs_busy[p]              = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed table, corner sequences and a randomized run
// against an array-based reference model (32x32 instance plus a 24-entry, 3-port one).
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rs_addr;
   logic [63:0] rs_data;
   logic [1:0]  rs_busy;
   logic        w_en;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [31:0] busy_vec;

   logic [14:0] n_rs_addr;
   logic [95:0] n_rs_data;
   logic [2:0]  n_rs_busy;
   logic        n_w_en;
   logic [4:0]  n_w_addr;
   logic [31:0] n_w_data;
   logic        n_rsv_en;
   logic [4:0]  n_rsv_addr;
   logic [23:0] n_busy_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(32), .NREGS(32), .NRPORTS(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_vec(busy_vec)
   );

   regfile_sb #(.XLEN(32), .NREGS(24), .NRPORTS(3)) u_np (
      .clk(clk), .rst_n(rst_n), .rs_addr(n_rs_addr), .rs_data(n_rs_data), .rs_busy(n_rs_busy),
      .w_en(n_w_en), .w_addr(n_w_addr), .w_data(n_w_data), .rsv_en(n_rsv_en),
      .rsv_addr(n_rsv_addr), .busy_vec(n_busy_vec)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      w_en = 1'b0; w_addr = '0; w_data = '0; rsv_en = 1'b0; rsv_addr = '0;
      n_w_en = 1'b0; n_w_addr = '0; n_w_data = '0; n_rsv_en = 1'b0; n_rsv_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: architectural state as plain arrays.
   logic [31:0] m_regs [32];
   logic        m_busy [32];

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (w_en && w_addr != 0) begin
         m_regs[w_addr] = w_data;
         m_busy[w_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
   endtask

   task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic b);
      d = (a == 0) ? 32'h0 : m_regs[a];
      b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (w_en && w_addr != 0 && w_addr == a) begin
         d = w_data;
         b = 1'b0;
      end
`endif
   endtask

   function automatic logic [31:0] model_bvec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rv;
      logic [4:0]  ra;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] e0;
      logic        eb0;
      logic [31:0] e1;
      logic        eb1;
   } vec_t;

   vec_t tbl [10];

   initial begin
      logic [31:0] ed;
      logic        eb;
      logic [31:0] d0;

      // Rows never read an address being written that cycle, so they hold with or without bypass.
      tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd5, 5'd7, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
      tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
      tbl[3] = '{1'b1, 5'd7,  32'h1234,     1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
      tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h1234,     1'b0, 32'h1234,     1'b0};
      tbl[5] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[6] = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd9, 5'd0, 5'd3, 32'h0,        1'b0, 32'h0,        1'b0};
      tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1};
      tbl[8] = '{1'b1, 5'd31, 32'h31,       1'b1, 5'd2, 5'd9, 5'd2, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0};
      tbl[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd31,5'd2, 32'h31,       1'b0, 32'h0,        1'b1};

      idle();
      rs_addr   = {5'd7, 5'd5};
      n_rs_addr = '0;
      rst_n     = 1'b0;
      #3;
      chk("reset_rs_data", rs_data, 64'h0);
      chk("reset_rs_busy", rs_busy, 2'b00);
      chk("reset_busy_vec", busy_vec, 32'h0);
      #9 rst_n = 1'b1;
      tick();

      for (int r = 0; r < 10; r++) begin
         w_en = tbl[r].we; w_addr = tbl[r].wa; w_data = tbl[r].wd;
         rsv_en = tbl[r].rv; rsv_addr = tbl[r].ra;
         rs_addr = {tbl[r].a1, tbl[r].a0};
         @(negedge clk);
         chk($sformatf("tbl%0d_data0", r), rs_data[31:0],  tbl[r].e0);
         chk($sformatf("tbl%0d_busy0", r), rs_busy[0],     tbl[r].eb0);
         chk($sformatf("tbl%0d_data1", r), rs_data[63:32], tbl[r].e1);
         chk($sformatf("tbl%0d_busy1", r), rs_busy[1],     tbl[r].eb1);
         tick();
      end
      idle();
      #1;
      chk("collision_busy_vec", busy_vec, 32'h0000_0204);

      // Write x3 while port 0 reads it in the same cycle.
      w_en = 1'b1; w_addr = 5'd3; w_data = 32'h55; rs_addr = {5'd9, 5'd3};
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_same_cycle", rs_data[31:0], 32'h55);
`else
      chk("nobypass_same_cycle", rs_data[31:0], 32'h0);
`endif
      chk("bypass_busy0", rs_busy[0], 1'b0);
      tick();
      idle();
      #1;
      chk("write_after_edge", rs_data[31:0], 32'h55);

      // Non-power-of-two depth: address 30 is out of range.
      n_w_en = 1'b1; n_w_addr = 5'd10; n_w_data = 32'h77;
      tick();
      n_w_addr = 5'd30; n_w_data = 32'h99; n_rsv_en = 1'b1; n_rsv_addr = 5'd30;
      tick();
      idle();
      n_rs_addr = {5'd30, 5'd30, 5'd30};
      #1;
      chk("np_oob_data", n_rs_data, 96'h0);
      chk("np_oob_busy", n_rs_busy, 3'b000);
      chk("np_busy_vec", n_busy_vec, 24'h0);
      n_rs_addr = {5'd10, 5'd10, 5'd10};
      #1;
      for (int p = 0; p < 3; p++) begin
         d0 = n_rs_data[p*32 +: 32];
         chk($sformatf("np_port%0d_x10", p), d0, 32'h77);
      end

      // Reservation on x9 is still pending; reset mid-cycle must clear everything at once.
      rs_addr = {5'd9, 5'd5};
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_x5", rs_data[31:0], 32'h0);
      chk("midreset_busy_vec", busy_vec, 32'h0);
      chk("midreset_busy1", rs_busy[1], 1'b0);
      chk("midreset_np_x10", n_rs_data[31:0], 32'h0);
      #2 rst_n = 1'b1;
      tick();
      model_reset();

      for (int n = 0; n < 400; n++) begin
         w_en     = 1'($urandom_range(1));
         w_addr   = 5'($urandom_range(31));
         w_data   = $urandom;
         rsv_en   = 1'($urandom_range(1));
         rsv_addr = ($urandom_range(3) == 0) ? w_addr : 5'($urandom_range(31));
         rs_addr  = ($urandom_range(3) == 0) ? {w_addr, w_addr}
                                            : {5'($urandom_range(31)), 5'($urandom_range(31))};
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            model_read(rs_addr[p*5 +: 5], ed, eb);
            chk($sformatf("rnd%0d_data%0d", n, p), rs_data[p*32 +: 32], ed);
            chk($sformatf("rnd%0d_busy%0d", n, p), rs_busy[p], eb);
         end
         chk($sformatf("rnd%0d_busy_vec", n), busy_vec, model_bvec());
         model_edge();
         tick();
      end
      idle();
      #1;
      chk("final_busy_vec", busy_vec, model_bvec());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, scoreboarded integer register file: the next-generation register file for the core datapath. Width, depth and read-port count are parameters. Register 0 is hardwired to zero, reset clears the array, and a per-register busy scoreboard tracks outstanding writes. It sits between decode/issue and the writeback stage. Issue reserves destinations, writeback writes and releases them, and operand reads return data plus a busy flag per port.

## Interface
- `XLEN`, 32, data width in bits (≥ 8)
- `NREGS`, 32, number of architectural registers (2..64; need not be a power of two)
- `NRPORTS`, 2, number of read ports (1..4)
- `AW`, `$clog2(NREGS)`, address width; derived, never overridden

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `rs_addr` in NRPORTS*AW: read addresses, port p at bits [p*AW +: AW]
- `rs_data` out NRPORTS*XLEN: read data, port p at bits [p*XLEN +: XLEN]
- `rs_busy` out NRPORTS: port p addresses a register with a pending write
- `w_en` in 1: writeback strobe
- `w_addr` in AW: writeback register index
- `w_data` in XLEN: writeback data
- `rsv_en` in 1: issue reserves a destination
- `rsv_addr` in AW: destination register to mark busy
- `busy_vec` out NREGS: registered scoreboard, bit i means register i is busy

## Operation
- Storage: `regs[0:NREGS-1]`, XLEN each. `regs[0]` is not implemented as a flop and always reads 0.
- Write: at the rising edge with `w_en`=1, `1 ≤ w_addr < NREGS` → `regs[w_addr] <= w_data`. Writes to 0 or to addresses ≥ NREGS are dropped silently.
- Scoreboard:
  - A write clears `busy_vec[w_addr]`.
  - `rsv_en` sets `busy_vec[rsv_addr]`.
  - Reserving 0 or an address ≥ NREGS is ignored.
- Simultaneous reserve and write to the same address: the reservation wins. Data is written and `busy_vec` stays 1, because a newer producer has been issued.
- Simultaneous reserve and write to different addresses: both take effect in the same edge.
- Read (combinational, every port independent):
  - address 0 or ≥ NREGS → `rs_data`=0, `rs_busy`=0
  - otherwise → `rs_data`=`regs[addr]`, `rs_busy`=`busy_vec[addr]`
- Bypass (see Configuration): when a write is in flight to the read address, `rs_data`=`w_data` and `rs_busy`=0. If a same-cycle reservation targets that address, `rs_busy`=0 still holds in the current cycle.
- Multiple read ports may address the same register and must return identical results.

## Timing
- Reset (`rst_n`=0, asynchronous assert, synchronous-safe deassert):
  - all `regs` = 0
  - `busy_vec` = 0
  - `rs_data` = 0 and `rs_busy` = 0 for every port
- Write latency: 1 edge. Without bypass, a read in the same cycle returns the old value and the new value appears after the edge.
- Reserve latency: 1 edge. `busy_vec` and `rs_busy` assert in the cycle after `rsv_en`.
- Reset asserted mid-operation: the array and scoreboard clear immediately, and any in-flight write or reserve is lost.
- Read path: purely combinational from `rs_addr` and `regs`/`busy_vec` (plus `w_*` when bypass is enabled). No added latency.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - writeback-to-read forwarding as described above
  - `rs_data` depends combinationally on `w_en`/`w_addr`/`w_data`
- Undefined:
  - no forwarding
  - a same-cycle read of the register being written returns the pre-write value and `rs_busy` reflects `busy_vec`
  - the read path is independent of `w_*`

## Test plan
- Reset with `XLEN`=32, `NREGS`=32:
  - Stimulus: write x5=0xDEADBEEF, pulse `rst_n` low mid-cycle.
  - Required: x5 reads 0 immediately and `busy_vec`=0.
- x0 protection:
  - Stimulus: `w_en`=1, `w_addr`=0, `w_data`=0xFFFFFFFF; `rsv_en`=1, `rsv_addr`=0.
  - Required: `rs_data` for address 0 is 0 on all ports, `busy_vec[0]`=0.
- Scoreboard:
  - Stimulus: reserve x7, wait one edge, read x7 on port 1.
  - Required: `rs_busy[1]`=1.
  - Stimulus: write x7=0x1234.
  - Required: after the edge, `rs_busy[1]`=0 and data=0x1234.
- Reserve/write collision:
  - Stimulus: same cycle, `rsv_addr`=`w_addr`=9, `w_data`=0xA5A5A5A5.
  - Required: next cycle x9=0xA5A5A5A5 and `busy_vec[9]`=1.
- Bypass:
  - Stimulus: write x3=0x55 while port 0 reads x3.
  - Required with `REGFILE_BYPASS_EN`: same-cycle `rs_data`=0x55.
  - Required without it: old value in that cycle, 0x55 after the edge.
- Non-power-of-two depth (`NREGS`=24, `NRPORTS`=3):
  - Stimulus: write to address 30, read address 30.
  - Required: write dropped, `rs_data`=0, `rs_busy`=0.
  - Required: the same address on all 3 ports returns identical data.
